// File: rtl/key_event_decoder.sv
// key_event_decoder: turns the debounced key level into one-clock press/release/click/
// double-click/long/repeat pulses. Define KEY_EVENT_REPEAT_EN to build auto-repeat in LONG.
module key_event_decoder #(
  parameter int F_CLK     = 50000000,
  parameter int F_TICK    = 1000,
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic key_state,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic dclick_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DIV   = F_CLK / F_TICK;
  localparam int PRE_W = $clog2(DIV);

  localparam logic [15:0] LONG_T   = 16'(LONG_MS);
  localparam logic [15:0] DCLICK_T = 16'(DCLICK_MS);

  if (DIV < 2 || DIV * F_TICK != F_CLK || LONG_MS < 1 || LONG_MS > 65535 ||
      DCLICK_MS < 1 || DCLICK_MS > 65535 || REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_param_err
    $error("key_event_decoder: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic             press_edge_p0, release_edge_p0;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [15:0]      cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage 0: synchroniser, history flop and registered edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      s1              <= 1'b1;
      s2              <= 1'b1;
      s3              <= 1'b1;
      pressed         <= 1'b0;
      press_edge_p0   <= 1'b0;
      release_edge_p0 <= 1'b0;
    end else begin
      s1              <= key_state;
      s2              <= s1;
      s3              <= s2;
      pressed         <= ~s2;
      press_edge_p0   <= s3 & ~s2;
      release_edge_p0 <= ~s3 & s2;
    end
  end

  // Free-running millisecond prescaler
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PRE_W'(DIV - 1)) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
      tick    <= 1'b0;
    end
  end

`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [15:0] REPEAT_T = 16'(REPEAT_MS);
`else
  assign repeat_pulse = 1'b0;
`endif

  // Stage 1: event FSM; an edge always beats a same-cycle tick or threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      dclick_pulse  <= 1'b0;
      long_pulse    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      dclick_pulse  <= 1'b0;
      long_pulse    <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
      if (tick) cnt <= sat_inc(cnt);

      case (state)
        IDLE: begin
          if (press_edge_p0) begin
            state       <= PRESS;
            cnt         <= '0;
            press_pulse <= 1'b1;
          end
        end
        PRESS: begin
          if (release_edge_p0) begin
            state         <= WAIT2;
            cnt           <= '0;
            release_pulse <= 1'b1;
          end else if (cnt == LONG_T) begin
            state      <= LONG;
            cnt        <= '0;
            long_pulse <= 1'b1;
          end
        end
        WAIT2: begin
          if (press_edge_p0) begin
            state       <= PRESS2;
            cnt         <= '0;
            press_pulse <= 1'b1;
          end else if (cnt == DCLICK_T) begin
            state       <= IDLE;
            cnt         <= '0;
            click_pulse <= 1'b1;
          end
        end
        PRESS2: begin
          if (release_edge_p0) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            dclick_pulse  <= 1'b1;
          end else if (cnt == LONG_T) begin
            state      <= LONG;
            cnt        <= '0;
            long_pulse <= 1'b1;
          end
        end
        LONG: begin
          if (release_edge_p0) begin
            state         <= IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
          end
`ifdef KEY_EVENT_REPEAT_EN
          else if (cnt == REPEAT_T) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
